// File: rtl/counter_bank.sv
// counter_bank: N_CH independent up/down counters, each with its own prescaler,
// wrap/saturate bound handling, compare-match and zero indication.
module counter_bank #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DIV_WIDTH = 24
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [N_CH-1:0]           ch_enable,
  input  logic [N_CH-1:0]           ch_clear,
  input  logic [N_CH-1:0]           ch_up,
  input  logic [N_CH-1:0]           ch_down,
  input  logic [N_CH-1:0]           ch_auto,
  input  logic [N_CH-1:0]           ch_dir,
  input  logic [N_CH-1:0]           ch_sat,
  input  logic [DIV_WIDTH*N_CH-1:0] div_load,
  input  logic [WIDTH*N_CH-1:0]     cmp_value,
  output logic [WIDTH*N_CH-1:0]     count_out,
  output logic [N_CH-1:0]           tc_pulse,
  output logic [N_CH-1:0]           cmp_pulse,
  output logic [N_CH-1:0]           zero_flag
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [DIV_WIDTH-1:0] reload;
    logic [DIV_WIDTH-1:0] presc_q;
    logic                 tick_q;
    logic [WIDTH-1:0]     cmp_val;
    logic [WIDTH-1:0]     cnt_q;
    logic [WIDTH-1:0]     cnt_nxt;
    logic                 tc_nxt;
    logic                 step_inc;
    logic                 step_dec;
    logic                 eq;
    logic                 eq_hist_q;
    logic                 tc_q;
    logic                 cmp_q;
    logic                 zero_q;

    assign reload  = div_load[g*DIV_WIDTH +: DIV_WIDTH];
    assign cmp_val = cmp_value[g*WIDTH +: WIDTH];
    assign eq      = (cnt_q == cmp_val);

    // Prescaler: reload while idle/cleared, tick for one cycle every reload+1 cycles
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        presc_q <= '0;
        tick_q  <= 1'b0;
      end else if (!ch_enable[g] || ch_clear[g]) begin
        presc_q <= reload;
        tick_q  <= 1'b0;
      end else if (presc_q == '0) begin
        presc_q <= reload;
        tick_q  <= 1'b1;
      end else begin
        presc_q <= presc_q - DIV_WIDTH'(1);
        tick_q  <= 1'b0;
      end
    end

    // Step request: up beats down beats auto tick; a losing tick is dropped
    always_comb begin
      step_inc = 1'b0;
      step_dec = 1'b0;
      if (!ch_clear[g] && ch_enable[g]) begin
        if (ch_up[g]) begin
          step_inc = 1'b1;
        end else if (ch_down[g]) begin
          step_dec = 1'b1;
        end else if (ch_auto[g] && tick_q) begin
          step_inc = ~ch_dir[g];
          step_dec = ch_dir[g];
        end
      end
    end

    // Next count and terminal-count event, with wrap or saturate at the bounds
    always_comb begin
      cnt_nxt = cnt_q;
      tc_nxt  = 1'b0;
      if (ch_clear[g]) begin
        cnt_nxt = '0;
      end else if (step_inc) begin
        if (cnt_q == CNT_MAX) begin
          if (!ch_sat[g]) begin
            cnt_nxt = '0;
            tc_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_q + CNT_ONE;
          tc_nxt  = ch_sat[g] && (cnt_q == (CNT_MAX - CNT_ONE));
        end
      end else if (step_dec) begin
        if (cnt_q == '0) begin
          if (!ch_sat[g]) begin
            cnt_nxt = CNT_MAX;
            tc_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
          tc_nxt  = ch_sat[g] && (cnt_q == CNT_ONE);
        end
      end
    end

    // Count, event pulses and zero level; eq history resets high to mask a match on release
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        cnt_q     <= '0;
        tc_q      <= 1'b0;
        cmp_q     <= 1'b0;
        zero_q    <= 1'b1;
        eq_hist_q <= 1'b1;
      end else begin
        cnt_q     <= cnt_nxt;
        tc_q      <= tc_nxt;
        cmp_q     <= eq & ~eq_hist_q;
        eq_hist_q <= eq;
        zero_q    <= (cnt_q == '0);
      end
    end

    assign count_out[g*WIDTH +: WIDTH] = cnt_q;
    assign tc_pulse[g]                 = tc_q;
    assign cmp_pulse[g]                = cmp_q;
    assign zero_flag[g]                = zero_q;
  end

endmodule
